// File: rtl/up_wishbone_master_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// up_wishbone_master_if : uP req/ack channels plus Wishbone classic bus, rev 1.0
// ---------------------------------------------------------------------------
interface up_wishbone_master_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int BUS_WIDTH     = 4
);
   localparam int c_WORD_AW = ADDRESS_WIDTH - $clog2(BUS_WIDTH);
   localparam int c_DW      = BUS_WIDTH * 8;

   logic                     up_rreq;
   logic                     up_rack;
   logic [c_WORD_AW-1:0]     up_raddr;
   logic [c_DW-1:0]          up_rdata;
   logic                     up_wreq;
   logic                     up_wack;
   logic [c_WORD_AW-1:0]     up_waddr;
   logic [c_DW-1:0]          up_wdata;
   logic                     bus_err;

   logic                     m_wb_cyc;
   logic                     m_wb_stb;
   logic                     m_wb_we;
   logic [ADDRESS_WIDTH-1:0] m_wb_addr;
   logic [c_DW-1:0]          m_wb_data_o;
   logic [BUS_WIDTH-1:0]     m_wb_sel;
   logic                     m_wb_ack;
   logic                     m_wb_err;
   logic [c_DW-1:0]          m_wb_data_i;

   modport master (
      input  up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
      input  m_wb_ack, m_wb_err, m_wb_data_i,
      output up_rack, up_rdata, up_wack, bus_err,
      output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel
   );

   modport slave (
      output up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
      output m_wb_ack, m_wb_err, m_wb_data_i,
      input  up_rack, up_rdata, up_wack, bus_err,
      input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel
   );
endinterface
`default_nettype wire

// File: rtl/up_wishbone_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// up_wishbone_master : uP register requests to Wishbone classic master, rev 1.0
// ---------------------------------------------------------------------------
module up_wishbone_master #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int BUS_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  wire logic            clk,
   input  wire logic            rstn,
   up_wishbone_master_if.master bus
);
   localparam int c_SHIFT = $clog2(BUS_WIDTH);
   localparam int c_DW    = BUS_WIDTH * 8;
   localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                   r_state,   w_state;
   logic [ADDRESS_WIDTH-1:0] r_addr,    w_addr;
   logic [c_DW-1:0]          r_wdata,   w_wdata;
   logic [c_DW-1:0]          r_rdata,   w_rdata;
   logic                     r_dir_wr,  w_dir_wr;
   logic [c_CNT_W-1:0]       r_cnt,     w_cnt;
   logic                     r_cyc,     w_cyc;
   logic                     r_we,      w_we;
   logic [BUS_WIDTH-1:0]     r_sel,     w_sel;
   logic                     r_rack,    w_rack;
   logic                     r_wack,    w_wack;
   logic                     r_bus_err, w_bus_err;

   logic w_timeout;
   logic w_term_err;

   // An ack arriving on the last allowed cycle still counts as a clean ack.
   assign w_timeout  = (TIMEOUT_CYCLES != 0) &&
                       (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_term_err = bus.m_wb_err || (w_timeout && !bus.m_wb_ack);

   always_comb begin
      w_state   = r_state;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      w_rdata   = r_rdata;
      w_dir_wr  = r_dir_wr;
      w_cnt     = r_cnt;
      w_cyc     = 1'b0;
      w_rack    = 1'b0;
      w_wack    = 1'b0;
      w_bus_err = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.up_wreq) begin
               w_addr   = ADDRESS_WIDTH'(bus.up_waddr) << c_SHIFT;
               w_wdata  = bus.up_wdata;
               w_dir_wr = 1'b1;
               w_cnt    = '0;
               w_cyc    = 1'b1;
               w_state  = BUS;
            end else if (bus.up_rreq) begin
               w_addr   = ADDRESS_WIDTH'(bus.up_raddr) << c_SHIFT;
               w_dir_wr = 1'b0;
               w_cnt    = '0;
               w_cyc    = 1'b1;
               w_state  = BUS;
            end
         end
         BUS: begin
            if (w_term_err) begin
               w_bus_err = 1'b1;
               w_rack    = !r_dir_wr;
               w_wack    = r_dir_wr;
               if (!r_dir_wr) begin
                  w_rdata = '1;
               end
               w_state   = RESP;
            end else if (bus.m_wb_ack) begin
               w_rack  = !r_dir_wr;
               w_wack  = r_dir_wr;
               if (!r_dir_wr) begin
                  w_rdata = bus.m_wb_data_i;
               end
               w_state = RESP;
            end else begin
               w_cyc = 1'b1;
               w_cnt = r_cnt + c_CNT_W'(1);
            end
         end
         RESP: begin
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase

      w_we  = w_cyc && w_dir_wr;
      w_sel = w_cyc ? '1 : '0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_dir_wr  <= 1'b0;
         r_cnt     <= '0;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= '0;
         r_rack    <= 1'b0;
         r_wack    <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_addr    <= w_addr;
         r_wdata   <= w_wdata;
         r_rdata   <= w_rdata;
         r_dir_wr  <= w_dir_wr;
         r_cnt     <= w_cnt;
         r_cyc     <= w_cyc;
         r_we      <= w_we;
         r_sel     <= w_sel;
         r_rack    <= w_rack;
         r_wack    <= w_wack;
         r_bus_err <= w_bus_err;
      end
   end

   assign bus.m_wb_cyc    = r_cyc;
   assign bus.m_wb_stb    = r_cyc;
   assign bus.m_wb_we     = r_we;
   assign bus.m_wb_sel    = r_sel;
   assign bus.m_wb_addr   = r_addr;
   assign bus.m_wb_data_o = r_wdata;
   assign bus.up_rdata    = r_rdata;
   assign bus.up_rack     = r_rack;
   assign bus.up_wack     = r_wack;
   assign bus.bus_err     = r_bus_err;
endmodule
`default_nettype wire

// File: tb/tb_up_wishbone_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_up_wishbone_master : scoreboard bench for the uP-to-Wishbone master, rev 1.0
// ---------------------------------------------------------------------------
module tb_up_wishbone_master;
   localparam int c_AW = 16;
   localparam int c_BW = 4;
   localparam int c_TO = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   up_wishbone_master_if #(.ADDRESS_WIDTH(c_AW), .BUS_WIDTH(c_BW)) bus ();

   up_wishbone_master #(
      .ADDRESS_WIDTH (c_AW),
      .BUS_WIDTH     (c_BW),
      .TIMEOUT_CYCLES(c_TO)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // slave model: mode 0 acks, 1 errs, 2 stays silent; terminates after slave_wait cycles
   int unsigned slave_wait = 0;
   int unsigned slave_mode = 0;
   int unsigned sw_cnt     = 0;
   logic [31:0] mem [0:255];
   logic        pl_en   = 1'b0;
   logic [7:0]  pl_idx  = 8'd0;
   logic [31:0] pl_data = 32'd0;
   logic        hit;

   assign hit             = bus.m_wb_cyc && bus.m_wb_stb && (sw_cnt == slave_wait);
   assign bus.m_wb_ack    = hit && (slave_mode == 0);
   assign bus.m_wb_err    = hit && (slave_mode == 1);
   assign bus.m_wb_data_i = mem[bus.m_wb_addr[9:2]];

   always @(posedge clk) begin
      if (!bus.m_wb_cyc || bus.m_wb_ack || bus.m_wb_err) sw_cnt <= 0;
      else                                                sw_cnt <= sw_cnt + 1;
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (bus.m_wb_cyc && bus.m_wb_we && bus.m_wb_ack) mem[bus.m_wb_addr[9:2]] <= bus.m_wb_data_o;
   end

   typedef struct packed { logic wr; logic err; logic [31:0] rdata; } resp_t;
   typedef struct packed { logic [15:0] addr; logic we; logic [31:0] data; } busx_t;
   resp_t resp_q[$];
   busx_t bus_q[$];
   busx_t cur;
   resp_t r;
   logic  prev_cyc = 1'b0;
   int    cyc_len  = 0;
   int    last_len = 0;
   int    idle_len = 1;
   int    n_cyc    = 0;

   always @(negedge clk) begin
      if (rstn) begin
         check("stb_eq_cyc", bus.m_wb_stb, bus.m_wb_cyc);
         if (bus.m_wb_cyc && !prev_cyc) begin
            n_cyc++;
            cyc_len = 1;
            check("idle_gap", idle_len >= 1, 1);
            check("cycle_expected", bus_q.size() != 0, 1);
            if (bus_q.size() != 0) cur = bus_q.pop_front();
         end else if (bus.m_wb_cyc) begin
            cyc_len++;
         end
         if (!bus.m_wb_cyc && prev_cyc) last_len = cyc_len;
         idle_len = bus.m_wb_cyc ? 0 : idle_len + 1;
         if (bus.m_wb_cyc) begin
            check("bus_addr", bus.m_wb_addr, cur.addr);
            check("bus_we", bus.m_wb_we, cur.we);
            check("bus_sel", bus.m_wb_sel, 4'hF);
            if (cur.we) check("bus_data_o", bus.m_wb_data_o, cur.data);
         end
         if (bus.up_rack || bus.up_wack) begin
            check("ack_expected", resp_q.size() != 0, 1);
            if (resp_q.size() != 0) begin
               r = resp_q.pop_front();
               check("ack_dir_w", bus.up_wack, r.wr);
               check("ack_dir_r", bus.up_rack, !r.wr);
               check("ack_bus_err", bus.bus_err, r.err);
               if (!r.wr) check("ack_rdata", bus.up_rdata, r.rdata);
            end
         end else begin
            check("bus_err_no_ack", bus.bus_err, 0);
         end
         prev_cyc = bus.m_wb_cyc;
      end else begin
         prev_cyc = 1'b0;
         idle_len = 1;
      end
   end

   task automatic push_exp(input bit wr, input logic [13:0] a, input logic [31:0] d, input bit err);
      resp_q.push_back('{wr, err, (wr ? 32'h0 : d)});
      bus_q.push_back('{{a, 2'b00}, wr, (wr ? d : 32'h0)});
   endtask

   task automatic wait_ack(input bit wr, input int bound, output int lat);
      bit seen = 1'b0;
      lat = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         lat++;
         seen = wr ? bus.up_wack : bus.up_rack;
      end
      if (wr) check("wack_in_time", seen, 1);
      else    check("rack_in_time", seen, 1);
      if (wr) bus.up_wreq = 1'b0;
      else    bus.up_rreq = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", wr ? bus.up_wack : bus.up_rack, 0);
   endtask

   task automatic do_write(input logic [13:0] a, input logic [31:0] d, input int unsigned waits,
                           input int unsigned mode, output int lat);
      slave_wait = waits;
      slave_mode = mode;
      push_exp(1'b1, a, d, mode != 0);
      bus.up_waddr = a;
      bus.up_wdata = d;
      bus.up_wreq  = 1'b1;
      wait_ack(1'b1, 40, lat);
   endtask

   task automatic do_read(input logic [13:0] a, input logic [31:0] exp, input int unsigned waits,
                          input int unsigned mode, output int lat);
      slave_wait = waits;
      slave_mode = mode;
      push_exp(1'b0, a, exp, mode != 0);
      bus.up_raddr = a;
      bus.up_rreq  = 1'b1;
      wait_ack(1'b0, 40, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n0;
      bus.up_rreq  = 1'b0;
      bus.up_wreq  = 1'b0;
      bus.up_raddr = '0;
      bus.up_waddr = '0;
      bus.up_wdata = '0;
      pl_idx  = 8'd2;
      pl_data = 32'hB0BDBEEF;
      pl_en   = 1'b1;
      repeat (3) @(negedge clk);
      pl_en = 1'b0;

      check("rst_cyc", bus.m_wb_cyc, 0);
      check("rst_stb", bus.m_wb_stb, 0);
      check("rst_we", bus.m_wb_we, 0);
      check("rst_sel", bus.m_wb_sel, 0);
      check("rst_addr", bus.m_wb_addr, 0);
      check("rst_data_o", bus.m_wb_data_o, 0);
      check("rst_acks", {bus.up_rack, bus.up_wack, bus.bus_err}, 0);
      check("rst_rdata", bus.up_rdata, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // write with two wait states: cyc high three cycles, ack four negedges after request
      do_write(14'h3, 32'hAAAA0002, 2, 0, lat);
      check("wr_latency", lat, 4);
      check("wr_cyc_len", last_len, 3);
      check("wr_data_hold", bus.m_wb_data_o, 32'hAAAA0002);

      // zero-wait read
      do_read(14'h2, 32'hB0BDBEEF, 0, 0, lat);
      check("rd_latency", lat, 2);
      check("rd_cyc_len", last_len, 1);
      repeat (3) @(negedge clk);
      check("rd_data_held", bus.up_rdata, 32'hB0BDBEEF);

      // simultaneous requests: write first, read of the same word second
      n0 = n_cyc;
      slave_wait = 1;
      slave_mode = 0;
      push_exp(1'b1, 14'h5, 32'h12345678, 1'b0);
      push_exp(1'b0, 14'h5, 32'h12345678, 1'b0);
      bus.up_waddr = 14'h5;
      bus.up_wdata = 32'h12345678;
      bus.up_raddr = 14'h5;
      bus.up_wreq  = 1'b1;
      bus.up_rreq  = 1'b1;
      wait_ack(1'b1, 40, lat);
      wait_ack(1'b0, 40, lat);
      repeat (2) @(negedge clk);
      check("simul_two_cycles", n_cyc - n0, 2);

      // silent slave on read: timeout
      do_read(14'h7, 32'hFFFFFFFF, 0, 2, lat);
      check("to_cyc_len", last_len, c_TO);
      check("to_rdata", bus.up_rdata, 32'hFFFFFFFF);

      // slave error on write
      do_write(14'h9, 32'h5555AAAA, 1, 1, lat);
      check("err_cyc_len", last_len, 2);

      // reset in the middle of a bus cycle
      slave_mode = 2;
      bus_q.push_back('{{14'h4, 2'b00}, 1'b0, 32'h0});
      bus.up_raddr = 14'h4;
      bus.up_rreq  = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_in_bus", bus.m_wb_cyc, 1);
      rstn = 1'b0;
      bus.up_rreq = 1'b0;
      @(negedge clk);
      check("mid_rst_ctl", {bus.m_wb_cyc, bus.m_wb_stb, bus.m_wb_we}, 0);
      check("mid_rst_acks", {bus.up_rack, bus.up_wack, bus.bus_err}, 0);
      check("mid_rst_rdata", bus.up_rdata, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      do_read(14'h2, 32'hB0BDBEEF, 1, 0, lat);
      check("post_rst_lat", lat, 3);

      // back-to-back writes then reads with random waits
      n0 = n_cyc;
      for (int i = 0; i < 16; i++)
         do_write(14'h10 + 14'(i), 32'h10000000 + 32'(2 * i), $urandom_range(0, 5), 0, lat);
      for (int i = 0; i < 16; i++)
         do_read(14'h10 + 14'(i), 32'h10000000 + 32'(2 * i), $urandom_range(0, 5), 0, lat);
      repeat (2) @(negedge clk);
      check("b2b_cycle_count", n_cyc - n0, 32);
      check("resp_q_empty", resp_q.size(), 0);
      check("bus_q_empty", bus_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
